// File: rtl/hilo_muldiv.sv
// hilo_muldiv
//   Iterative multiply/divide unit with the architectural HI/LO registers.
//   MULT/MULTU use a shift-add loop over a 64-bit accumulator and DIV/DIVU
//   use a restoring loop with a 33-bit trial subtraction. Both take 32
//   iterations followed by one sign-fix/write-back cycle. MTHI/MTLO write
//   HI/LO in a single cycle while the unit is idle.
//
// Ports
//   Clk    rising-edge clock
//   Reset  synchronous, active-high; clears all state
//   Start  launch request, honoured only while Busy=0
//   Op     000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//          110/111 no-op
//   A      rs operand: multiplicand, dividend or MTHI/MTLO source
//   B      rt operand: multiplier or divisor
//   HI/LO  architectural result registers
//   Busy   high while a mul/div is in flight (RUN or FIX)
//   Done   one-cycle pulse after HI/LO are written by a mul/div
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t state, state_nxt;

  logic [4:0]         cnt;
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo;   // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0]   a_raw;    // original A, needed for divide-by-zero HI
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  // Launch decode: Op[2]=0 selects mul/div, Op[1] selects divide,
  // Op[0]=0 selects the signed flavour.
  logic             launch;
  logic             is_div;
  logic             is_signed;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign launch    = (state == IDLE) && Start && !Op[2];
  assign is_div    = Op[1];
  assign is_signed = !Op[0];
  assign mag_a     = (is_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (is_signed && B[WIDTH-1]) ? -B : B;

  // One shift-add step: add the multiplicand when the current multiplier
  // bit is set, then shift the whole 64-bit accumulator right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

  // One restoring step: shift the next dividend bit into the remainder and
  // try subtracting the divisor. The restored remainder is always below the
  // divisor, so it fits back into WIDTH bits.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_raw = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quot_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN: begin
        Busy = 1'b1;
        if (cnt == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        Busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with HI/LO so an aborted
  // operation leaves no stale counter or flags behind; non-blocking
  // assignments keep every register reading the pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      a_raw  <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            cnt    <= '0;
            acc_hi <= '0;
            op_div <= is_div;
            a_raw  <= A;
            div0   <= is_div && (B == '0);
            neg_q  <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r  <= is_signed && A[WIDTH-1];
            if (is_div) begin
              opnd   <= mag_b;
              acc_lo <= mag_a;
            end else begin
              opnd   <= mag_a;
              acc_lo <= mag_b;
            end
          end else if (Start && (Op == OP_MTHI)) begin
            HI <= A;
          end else if (Start && (Op == OP_MTLO)) begin
            LO <= A;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_div) begin
            if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          Done <= 1'b1;
          if (op_div) begin
            // A zero divisor skips sign correction entirely.
            if (div0) begin
              HI <= a_raw;
              LO <= '1;
            end else begin
              HI <= rem_fix;
              LO <= quot_fix;
            end
          end else begin
            HI <= prod_fix[2*WIDTH-1:WIDTH];
            LO <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv
//   Self-checking bench for hilo_muldiv. Stimulus pushes the expected
//   {HI,LO} of each mul/div into a queue; a monitor pops and compares on
//   every Done pulse and also checks the Busy window length.
module tb_hilo_muldiv;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;

  hilo_muldiv #(.WIDTH(32)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .HI   (HI),
    .LO   (LO),
    .Busy (Busy),
    .Done (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb[$];
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  bit          noise_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with the architectural
  // divide-by-zero and overflow results.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int     sa;
    int     sb_;
    longint p;
    int     q;
    int     r;
    sa  = a;
    sb_ = b;
    case (op)
      3'd0: begin
        p = longint'(sa) * longint'(sb_);
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb_;
        r = sa % sb_;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: compare results on Done and check the Busy window length.
  int busy_len = 0;
  bit prev_done = 0;
  always @(negedge Clk) begin
    logic [63:0] exp;
    if (Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp = sb.pop_front();
        check("result_hilo", {HI, LO}, exp);
        check("busy_len", 64'(busy_len), 64'd33);
        check("done_single", 64'(prev_done), 64'd0);
      end
    end
    prev_done = Done;
    if (Busy) busy_len++;
    else      busy_len = 0;
  end

  // Waits (on negedges) until Busy is low; optionally drives junk inputs
  // while busy, which the DUT must ignore.
  task automatic wait_idle(input bit noise);
    for (int i = 0; i < 100; i++) begin
      if (!Busy) return;
      if (noise) begin
        Start = 1'($urandom_range(0, 1));
        Op    = 3'($urandom_range(0, 7));
        A     = $urandom;
        B     = $urandom;
      end
      @(negedge Clk);
    end
    check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_idle(noise_en);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    if (op <= 3'd3) begin
      {m_hi, m_lo} = ref_model(op, a, b);
      sb.push_back({m_hi, m_lo});
    end else begin
      if (op == 3'd4) m_hi = a;
      if (op == 3'd5) m_lo = a;
      check("mt_hi", 64'(HI), 64'(m_hi));
      check("mt_lo", 64'(LO), 64'(m_lo));
      check("mt_busy", 64'(Busy), 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);

    // Directed cases.
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd3, 32'd100, 32'd0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd0);
    wait_idle(0);
    do_op(3'd4, 32'h1234_5678, 32'd0);
    do_op(3'd5, 32'h9ABC_DEF0, 32'd0);
    check("mt_pair_hi", 64'(HI), 64'h1234_5678);
    check("mt_pair_lo", 64'(LO), 64'h9ABC_DEF0);
    do_op(3'd6, 32'hAAAA_AAAA, 32'd0);
    do_op(3'd7, 32'h5555_5555, 32'd0);

    // MTLO while busy must be ignored.
    do_op(3'd1, 32'd5, 32'd6);
    repeat (9) @(negedge Clk);
    Start = 1'b1;
    Op    = 3'd5;
    A     = 32'h0000_DEAD;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle(0);
    @(negedge Clk);
    check("ignored_mtlo_lo", 64'(LO), 64'd30);
    check("ignored_mtlo_hi", 64'(HI), 64'd0);

    // Reset mid-divide aborts; Start with MTHI in the same cycle loses.
    do_op(3'd3, 32'd1000, 32'd7);
    repeat (14) @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b1;
    Op    = 3'd4;
    A     = 32'hFFFF_0000;
    @(negedge Clk);
    Reset = 1'b0;
    Start = 1'b0;
    void'(sb.pop_back());
    m_hi = 0;
    m_lo = 0;
    check("abort_hi", 64'(HI), 64'd0);
    check("abort_lo", 64'(LO), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    do_op(3'd3, 32'd1000, 32'd7);
    wait_idle(0);
    @(negedge Clk);
    check("after_abort_lo", 64'(LO), 64'd142);
    check("after_abort_hi", 64'(HI), 64'd6);

    // Randomized ops, back-to-back, with junk inputs while busy.
    noise_en = 1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(op, a, b);
    end
    noise_en = 0;
    wait_idle(0);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("final_hi", 64'(HI), 64'(m_hi));
    check("final_lo", 64'(LO), 64'(m_lo));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits in the execute stage beside the ALU and consumes the same operand pair delivered by the register-read and ALU-source select muxes. It runs MULT/MULTU/DIV/DIVU iteratively over 32 cycles and services MTHI/MTLO in one cycle. HI/LO feed the MFHI/MFLO write-back select.

## Interface
Parameters
- WIDTH, 32, operand and HI/LO width; only 32 is supported and verified.

Ports
- Clk  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- Start  input  1  launch request; sampled only when Busy=0.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- A  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- B  input  WIDTH  rt operand: multiplier or divisor.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- Busy  output  1  high while an iterative operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO update from a mul/div.

## Operation
- States: IDLE, RUN, FIX.
- Reset values: HI=0, LO=0, Busy=0, Done=0, state=IDLE, iteration counter=0.
- IDLE with Start=1 and Op in 000..011:
  - Latch |A| and |B|. Signed ops take the two's-complement magnitude; unsigned ops take the operand as is.
  - Latch the result-sign flags: quotient/product sign = A[31]^B[31]; remainder sign = A[31]. Both are 0 for unsigned ops.
  - Clear counter, go to RUN, set Busy=1.
- IDLE with Start=1 and Op=100: HI<=A. Op=101: LO<=A. State stays IDLE; Busy and Done stay 0.
- IDLE with Start=1 and Op=110/111: no effect.
- RUN, one iteration per cycle, counter 0..31:
  - Multiply: shift-add, 64-bit accumulator {P_hi, P_lo}.
  - Divide: restoring, 33-bit partial remainder, one quotient bit per cycle.
  - When counter=31, go to FIX.
- FIX, one cycle:
  - Apply sign correction: negate the 64-bit product, the quotient, or the remainder when its sign flag is set.
  - Write the result: multiply gives HI=product[63:32], LO=product[31:0]; divide gives HI=remainder, LO=quotient.
  - Go to IDLE, drive Busy=0 and Done=1 for exactly that cycle.
- Divide by zero, detected at launch, still takes the full latency:
  - Unsigned: LO=32'hFFFFFFFF, HI=A.
  - Signed: LO=32'hFFFFFFFF, HI=A, with no sign correction.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of magnitude arithmetic.
- Start while Busy=1 is ignored entirely, including MTHI/MTLO. A and B changing during RUN have no effect.
- HI/LO hold their previous values during RUN/FIX until the FIX write.

## Timing
- Launch edge N: Start=1 with Busy=0. After N, Busy=1.
- Iterations run on edges N+1 .. N+32. The FIX write happens on edge N+33.
- After N+33: HI/LO valid, Done=1, Busy=0. Done returns to 0 after N+34 unless a new op completes then.
- Busy is high for exactly 33 cycles. Latency from the Start edge to valid HI/LO is 33 edges.
- Back-to-back: Start may be asserted in the cycle Done=1, giving a new launch on edge N+34.
- MTHI/MTLO: value visible on HI/LO the cycle after the write edge; single-cycle, no Busy.
- Reset during RUN or FIX: abort, HI=LO=0, Busy=Done=0, IDLE after the edge; no partial write.
- Reset and Start in the same cycle: Reset wins.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001, Done pulses once, Busy high for exactly 33 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=100; DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI=0x12345678, LO=0x9ABCDEF0, Busy/Done never assert.
- Launch MULTU 5*6, assert Start with MTLO A=0xDEAD at cycle 10 -> ignored; final LO=30, HI=0.
- Launch DIVU 1000/7, assert Reset at cycle 15 -> HI=LO=0, Busy=Done=0 next cycle; a following DIVU 1000/7 gives LO=142, HI=6.
